iir_biquad_sequencer: RTL and testbench

//   Time-multiplexed controller for a cascade of second-order IIR sections sharing one multiplier/accumulator.

---
 rtl/iir_biquad_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_iir_biquad_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iir_biquad_sequencer.sv
// Time-multiplexed cascade of biquads sharing one multiply/accumulate path.
// Define IIR_SAT_EN to saturate section outputs instead of wrapping them.
module iir_biquad_sequencer #(
    parameter int DATA_W = 32,
    parameter int COEF_W = 32,
    parameter int FRAC   = 20,
    parameter int N_SEC  = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_W-1:0]            in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_data,
    input  logic                         cfg_we,
    input  logic [$clog2(N_SEC*5)-1:0]   cfg_addr,
    input  logic [COEF_W-1:0]            cfg_wdata,
    output logic                         cfg_err,
    input  logic                         clr_state,
    output logic                         busy
);

    localparam int NC    = N_SEC * 5;
    localparam int AW    = $clog2(NC);
    localparam int SW    = (N_SEC > 1) ? $clog2(N_SEC) : 1;
    localparam int PW    = DATA_W + COEF_W;
    localparam int ACC_W = PW + 3;

    localparam logic signed [COEF_W-1:0] B0_ONE = COEF_W'(1) << FRAC;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        WB,
        OUT
    } state_t;

    state_t                    state;
    logic [SW-1:0]             sec;
    logic [2:0]                k;
    logic signed [DATA_W-1:0]  x;
    logic signed [ACC_W-1:0]   acc;

    logic signed [COEF_W-1:0]  coef [NC];
    logic signed [DATA_W-1:0]  z1b  [N_SEC];
    logic signed [DATA_W-1:0]  z2b  [N_SEC];
    logic signed [DATA_W-1:0]  z1a  [N_SEC];
    logic signed [DATA_W-1:0]  z2a  [N_SEC];

    logic [AW-1:0]             cidx;
    logic signed [DATA_W-1:0]  opa;
    logic signed [COEF_W-1:0]  cval;
    logic signed [PW-1:0]      prod;
    logic signed [ACC_W-1:0]   ext;
    logic signed [ACC_W-1:0]   acc_nx;
    logic signed [DATA_W-1:0]  y;
    logic                      last;

    assign last = (sec == SW'(N_SEC - 1));
    assign cidx = AW'(sec) * AW'(5) + AW'(k);

    always_comb begin
        opa = x;
        unique case (k)
            3'd0:    opa = x;
            3'd1:    opa = z1b[sec];
            3'd2:    opa = z2b[sec];
            3'd3:    opa = z1a[sec];
            3'd4:    opa = z2a[sec];
            default: opa = x;
        endcase
        cval = coef[cidx];
        prod = opa * cval;
        ext  = {{(ACC_W - PW){prod[PW-1]}}, prod};
        // feedback taps enter with negative sign
        if (k == 3'd0)
            acc_nx = ext;
        else if (k >= 3'd3)
            acc_nx = acc - ext;
        else
            acc_nx = acc + ext;
    end

`ifdef IIR_SAT_EN
    logic signed [ACC_W-1:0]    sh;
    logic [ACC_W-DATA_W:0]      top;
    always_comb begin
        sh  = acc >>> FRAC;
        top = sh[ACC_W-1:DATA_W-1];
        if ((&top) || !(|top))
            y = sh[DATA_W-1:0];
        else if (sh[ACC_W-1])
            y = {1'b1, {(DATA_W-1){1'b0}}};
        else
            y = {1'b0, {(DATA_W-1){1'b1}}};
    end
`else
    always_comb begin
        y = DATA_W'(acc >>> FRAC);
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sec       <= '0;
            k         <= '0;
            x         <= '0;
            acc       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            cfg_err   <= 1'b0;
            busy      <= 1'b0;
            for (int i = 0; i < NC; i++)
                coef[i] <= (i % 5 == 0) ? B0_ONE : '0;
            for (int i = 0; i < N_SEC; i++) begin
                z1b[i] <= '0;
                z2b[i] <= '0;
                z1a[i] <= '0;
                z2a[i] <= '0;
            end
        end else begin
            cfg_err <= cfg_we &&
                       (state != IDLE || cfg_addr >= AW'(NC));
            unique case (state)
                IDLE: begin
                    if (clr_state) begin
                        for (int i = 0; i < N_SEC; i++) begin
                            z1b[i] <= '0;
                            z2b[i] <= '0;
                            z1a[i] <= '0;
                            z2a[i] <= '0;
                        end
                    end
                    if (cfg_we && cfg_addr < AW'(NC))
                        coef[cfg_addr] <= cfg_wdata;
                    if (in_valid) begin
                        x        <= in_data;
                        sec      <= '0;
                        k        <= '0;
                        state    <= MAC;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                MAC: begin
                    acc <= acc_nx;
                    if (k == 3'd4)
                        state <= WB;
                    else
                        k <= k + 3'd1;
                end
                WB: begin
                    z2b[sec] <= z1b[sec];
                    z1b[sec] <= x;
                    z2a[sec] <= z1a[sec];
                    z1a[sec] <= y;
                    x        <= y;
                    if (last) begin
                        state     <= OUT;
                        out_valid <= 1'b1;
                        out_data  <= y;
                    end else begin
                        sec   <= sec + SW'(1);
                        k     <= '0;
                        state <= MAC;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iir_biquad_sequencer.sv
// Directed bench for iir_biquad_sequencer (N_SEC=3, Q20 coefficients).
module tb_iir_biquad_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic        cfg_err;
    logic        clr_state;
    logic        busy;

    iir_biquad_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_err   (cfg_err),
        .clr_state (clr_state),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] b0;
        logic [31:0] a1;
        logic        clr;
        logic [31:0] din;
        logic [31:0] exp;
    } vec_t;

    localparam int NV = 11;
    vec_t vt [NV];

    int          pass = 0;
    int          total = 0;
    int          lat;
    int          bc;
    logic [31:0] d;
    logic [31:0] held;
    logic        e;
    logic        ok;

    task automatic check(input string nm,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got === exp)
            pass++;
        else
            $display("FAIL %s: got 0x%08h expected 0x%08h",
                     nm, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [3:0] a,
                             input logic [31:0] v,
                             output logic err);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = v;
        tick();
        cfg_we = 1'b0;
        err    = cfg_err;
    endtask

    task automatic do_clr();
        clr_state = 1'b1;
        tick();
        clr_state = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        if (!in_ready)
            check("ready_timeout", 32'(in_ready), 32'd1);
    endtask

    task automatic start(input logic [31:0] v);
        wait_ready();
        in_valid = 1'b1;
        in_data  = v;
        tick();
        in_valid = 1'b0;
        in_data  = 32'hDEAD_BEEF;
    endtask

    task automatic finish(output int l, output logic [31:0] v,
                          output int b);
        int cyc = 0;
        l = -1;
        v = '0;
        b = 0;
        while (busy && cyc < 200) begin
            b++;
            if (out_valid && l < 0) begin
                l = cyc;
                v = out_data;
            end
            tick();
            cyc++;
        end
        if (busy)
            check("busy_timeout", 32'(busy), 32'd0);
    endtask

    task automatic run(input logic [31:0] v, output int l,
                       output logic [31:0] r, output int b);
        start(v);
        finish(l, r, b);
    endtask

    task automatic wait_ovalid();
        int n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        if (!out_valid)
            check("ovalid_timeout", 32'(out_valid), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = '{32'h0010_0000, 0, 1, 1000, 1000};
        vt[1]  = '{32'h0008_0000, 0, 1, 1000, 500};
        vt[2]  = '{32'h0008_0000, 0, 1, -7, -4};
        vt[3]  = '{32'h0010_0000, -(1 << 19), 1, 1024, 1024};
        vt[4]  = '{32'h0010_0000, -(1 << 19), 0, 0, 512};
        vt[5]  = '{32'h0010_0000, -(1 << 19), 0, 0, 256};
        vt[6]  = '{32'h0010_0000, -(1 << 19), 1, 0, 0};
        vt[7]  = '{32'h0010_0000, 0, 1, -123456, -123456};
        vt[8]  = '{-(1 << 20), 0, 1, 5000, -5000};
        vt[9]  = '{32'h0010_0000, 0, 1, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
`ifdef IIR_SAT_EN
        vt[10] = '{32'h4000_0000, 0, 1, 1 << 22, 32'h7FFF_FFFF};
`else
        vt[10] = '{32'h4000_0000, 0, 1, 1 << 22, 32'h0000_0000};
`endif

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_wdata = '0;
        clr_state = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cfg_err", 32'(cfg_err), 32'd0);

        run(1000, lat, d, bc);
        check("rstcoef_out", d, 32'd1000);
        check("rstcoef_lat", 32'(lat), 32'd18);
        check("rstcoef_busy", 32'(bc), 32'd19);

        for (int i = 0; i < NV; i++) begin
            cfg_write(4'd0, vt[i].b0, e);
            check($sformatf("v%0d_cfgerr", i), 32'(e), 32'd0);
            cfg_write(4'd3, vt[i].a1, e);
            if (vt[i].clr)
                do_clr();
            run(vt[i].din, lat, d, bc);
            check($sformatf("v%0d_out", i), d, vt[i].exp);
            check($sformatf("v%0d_lat", i), 32'(lat), 32'd18);
            check($sformatf("v%0d_busy", i), 32'(bc), 32'd19);
        end

        cfg_write(4'd0, 32'h0010_0000, e);
        cfg_write(4'd3, 32'd0, e);
        do_clr();

        out_ready = 1'b0;
        start(777);
        wait_ovalid();
        held     = out_data;
        ok       = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'd5;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_data !== held || !out_valid || in_ready)
                ok = 1'b0;
        end
        check("t4_hold", 32'(ok), 32'd1);
        check("t4_data", held, 32'd777);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("t4_rel_ovalid", 32'(out_valid), 32'd0);
        check("t4_rel_ready", 32'(in_ready), 32'd1);
        check("t4_rel_busy", 32'(busy), 32'd0);

        start(1000);
        tick();
        tick();
        cfg_we    = 1'b1;
        cfg_addr  = 4'd0;
        cfg_wdata = 32'h0008_0000;
        tick();
        cfg_we = 1'b0;
        check("t5_busy_err", 32'(cfg_err), 32'd1);
        tick();
        check("t5_err_pulse", 32'(cfg_err), 32'd0);
        finish(lat, d, bc);
        check("t5_inflight", d, 32'd1000);
        run(1000, lat, d, bc);
        check("t5_unchanged", d, 32'd1000);
        cfg_write(4'd15, 32'd123, e);
        check("t5_addr15_err", 32'(e), 32'd1);
        run(1000, lat, d, bc);
        check("t5_addr15_noeff", d, 32'd1000);

        wait_ready();
        cfg_we    = 1'b1;
        cfg_addr  = 4'd0;
        cfg_wdata = 32'h0008_0000;
        in_valid  = 1'b1;
        in_data   = 32'd1000;
        tick();
        cfg_we   = 1'b0;
        in_valid = 1'b0;
        check("cfg_accept_err", 32'(cfg_err), 32'd0);
        finish(lat, d, bc);
        check("cfg_accept_out", d, 32'd500);
        cfg_write(4'd0, 32'h0010_0000, e);

        cfg_write(4'd3, -(1 << 19), e);
        do_clr();
        run(1024, lat, d, bc);
        check("clr_pre", d, 32'd1024);
        start(0);
        clr_state = 1'b1;
        tick();
        clr_state = 1'b0;
        finish(lat, d, bc);
        check("clr_busy_ign", d, 32'd512);
        wait_ready();
        clr_state = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'd0;
        tick();
        clr_state = 1'b0;
        in_valid  = 1'b0;
        finish(lat, d, bc);
        check("clr_accept", d, 32'd0);
        cfg_write(4'd3, 32'd0, e);

        cfg_write(4'd0, 32'h0008_0000, e);
        start(1000);
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("mid_rst_ovalid", 32'(out_valid), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        run(1000, lat, d, bc);
        check("mid_rst_coef", d, 32'd1000);

        out_ready = 1'b0;
        start(42);
        wait_ovalid();
        check("out_rst_pre", out_data, 32'd42);
        rst = 1'b1;
        #1;
        check("out_rst_ovalid", 32'(out_valid), 32'd0);
        check("out_rst_data", out_data, 32'd0);
        tick();
        rst       = 1'b0;
        out_ready = 1'b1;
        tick();
        check("out_rst_ready", 32'(in_ready), 32'd1);

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
